// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC scan scheduler.
// The optional 4-sample averaging path is enabled with the ADC_AVG_EN macro.
package adc_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_START,
        ST_WAIT,
        ST_STORE,
        ST_DONE
    } state_t;

    localparam int DEF_PERIOD_CYC  = 25000;
    localparam int DEF_TIMEOUT_CYC = 250;
    localparam int AVG_SHIFT       = 2;

endpackage

// File: rtl/adc_sched_tick.sv
// Enable-gated period counter; pulses tick for one cycle each time it wraps to 0.
module adc_sched_tick
    import adc_sched_pkg::*;
#(
    parameter int PERIOD_CYC = DEF_PERIOD_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (!enable) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CNT_W'(PERIOD_CYC - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/adc_scan_scheduler.sv
// Scans masked ADC channels on demand or periodically, supervises each conversion
// with a timeout and keeps a per-channel result bank. Optional: ADC_AVG_EN (4-sample averaging).
module adc_scan_scheduler
    import adc_sched_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int CH_W        = 1,
    parameter int DATA_W      = 8,
    parameter int PERIOD_CYC  = DEF_PERIOD_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              scan_now,
    input  logic [N_CH-1:0]   ch_mask,
    output logic              conv_start,
    output logic [CH_W-1:0]   conv_addr,
    input  logic              conv_done,
    input  logic [DATA_W-1:0] conv_data,
    output logic              smp_valid,
    output logic [CH_W-1:0]   smp_ch,
    output logic [DATA_W-1:0] smp_data,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr
);

    localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;

    state_t            state, state_nx;
    logic [N_CH-1:0]   mask_q;
    logic [CH_W:0]     idx_q;
    logic [TO_W-1:0]   to_cnt;
    logic              ok_q;
    logic              hit_q;
    logic [DATA_W-1:0] res_q;
    logic [DATA_W-1:0] bank [N_CH];
    logic              tick;
    logic              trig;
    logic              to_hit;
    logic              sel_found;
    logic [CH_W-1:0]   sel_ch;

`ifdef ADC_AVG_EN
    logic [DATA_W+1:0] acc     [N_CH];
    logic [1:0]        acc_cnt [N_CH];
    logic [DATA_W+1:0] acc_sum;

    assign acc_sum = acc[conv_addr] + (DATA_W+2)'(conv_data);
`endif

    adc_sched_tick #(
        .PERIOD_CYC (PERIOD_CYC)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    assign trig   = (tick || scan_now) && (ch_mask != '0);
    assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Lowest latched channel at or above the scan index
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (i >= int'(idx_q))) begin
                sel_found = 1'b1;
                sel_ch    = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (trig) state_nx = ST_SELECT;
            ST_SELECT: state_nx = sel_found ? ST_START : ST_DONE;
            ST_START:  state_nx = ST_WAIT;
            ST_WAIT:   if (conv_done || to_hit) state_nx = ST_STORE;
            ST_STORE:  state_nx = ST_SELECT;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        conv_start = (state == ST_START);
        busy       = (state == ST_SELECT) || (state == ST_START) ||
                     (state == ST_WAIT)   || (state == ST_STORE);
        smp_valid  = (state == ST_STORE) && ok_q && hit_q;
    end

    assign smp_ch   = conv_addr;
    assign smp_data = res_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q      <= '0;
            idx_q       <= '0;
            conv_addr   <= '0;
            to_cnt      <= '0;
            ok_q        <= 1'b0;
            hit_q       <= 1'b0;
            res_q       <= '0;
            timeout_err <= 1'b0;
            for (int i = 0; i < N_CH; i++) bank[i] <= '0;
`ifdef ADC_AVG_EN
            for (int i = 0; i < N_CH; i++) begin
                acc[i]     <= '0;
                acc_cnt[i] <= '0;
            end
`endif
        end else begin
            if (err_clr) timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (trig) begin
                        mask_q <= ch_mask;
                        idx_q  <= '0;
                    end
                end
                ST_SELECT: begin
                    if (sel_found) conv_addr <= sel_ch;
                end
                ST_START: begin
                    to_cnt <= '0;
                end
                ST_WAIT: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (conv_done) begin
                        ok_q <= 1'b1;
`ifdef ADC_AVG_EN
                        if (acc_cnt[conv_addr] == 2'd3) begin
                            hit_q              <= 1'b1;
                            res_q              <= DATA_W'(acc_sum >> AVG_SHIFT);
                            acc[conv_addr]     <= '0;
                            acc_cnt[conv_addr] <= '0;
                        end else begin
                            hit_q              <= 1'b0;
                            acc[conv_addr]     <= acc_sum;
                            acc_cnt[conv_addr] <= acc_cnt[conv_addr] + 1'b1;
                        end
`else
                        hit_q <= 1'b1;
                        res_q <= conv_data;
`endif
                    end else if (to_hit) begin
                        // A timeout wins over a same-cycle err_clr
                        ok_q        <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end
                ST_STORE: begin
                    if (ok_q && hit_q) bank[conv_addr] <= res_q;
                    idx_q <= (CH_W+1)'(conv_addr) + 1'b1;
                end
                ST_DONE: begin
                    idx_q <= '0;
                end
                default: ;
            endcase
        end
    end

    // Registered bank read; a same-cycle write is seen one cycle later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                   rd_data <= '0;
        else if (int'(rd_ch) < N_CH)  rd_data <= bank[rd_ch];
        else                          rd_data <= '0;
    end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed scoreboard bench for adc_scan_scheduler with a simple ADC controller model.
module tb_adc_scan_scheduler;
    localparam int N_CH   = 2;
    localparam int CH_W   = 1;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              scan_now;
    logic [N_CH-1:0]   ch_mask;
    logic              conv_start;
    logic [CH_W-1:0]   conv_addr;
    logic              conv_done;
    logic [DATA_W-1:0] conv_data;
    logic              smp_valid;
    logic [CH_W-1:0]   smp_ch;
    logic [DATA_W-1:0] smp_data;
    logic [CH_W-1:0]   rd_ch;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              timeout_err;
    logic              err_clr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_start  = 0;
    int n_smp    = 0;

    int exp_addr [$];
    int exp_smp  [$];
    int start_cyc[$];
    int avg_q    [$];

    logic [DATA_W-1:0] mdl_val [N_CH];
    logic              mdl_done;
    logic [DATA_W-1:0] mdl_data;
    logic              spur_done;
    int                hang_ch;
    logic              pend;
    int                lat;
    int                pend_ch;

    assign conv_done = mdl_done | spur_done;
    assign conv_data = mdl_data;

    adc_scan_scheduler #(
        .N_CH        (N_CH),
        .CH_W        (CH_W),
        .DATA_W      (DATA_W),
        .PERIOD_CYC  (100),
        .TIMEOUT_CYC (250)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .scan_now    (scan_now),
        .ch_mask     (ch_mask),
        .conv_start  (conv_start),
        .conv_addr   (conv_addr),
        .conv_done   (conv_done),
        .conv_data   (conv_data),
        .smp_valid   (smp_valid),
        .smp_ch      (smp_ch),
        .smp_data    (smp_data),
        .rd_ch       (rd_ch),
        .rd_data     (rd_data),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ADC controller model: answers 3 cycles after a start unless the channel hangs
    always @(negedge clk) begin
        if (!reset) begin
            mdl_done = 1'b0;
            pend     = 1'b0;
            lat      = 0;
        end else begin
            mdl_done = 1'b0;
            if (pend) begin
                lat--;
                if (lat == 0) begin
                    pend     = 1'b0;
                    mdl_done = 1'b1;
                    if (avg_q.size() > 0) mdl_data = DATA_W'(avg_q.pop_front());
                    else                  mdl_data = mdl_val[pend_ch];
                end
            end
            if (conv_start && (int'(conv_addr) != hang_ch)) begin
                pend    = 1'b1;
                lat     = 3;
                pend_ch = int'(conv_addr);
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        int e;
        cyc++;
        if (reset && conv_start) begin
            n_start++;
            start_cyc.push_back(cyc);
            if (exp_addr.size() == 0) chk("start_unexpected", 32'(conv_start), 0);
            else chk("start_addr", 32'(conv_addr), 32'(exp_addr.pop_front()));
        end
        if (reset && smp_valid) begin
            n_smp++;
            if (exp_smp.size() == 0) chk("smp_unexpected", 32'(smp_valid), 0);
            else begin
                e = exp_smp.pop_front();
                chk("smp_ch", 32'(smp_ch), 32'(e >> 8));
                chk("smp_data", 32'(smp_data), 32'(e & 8'hFF));
            end
        end
    end

    task automatic pulse_scan();
        @(negedge clk);
        scan_now = 1'b1;
        @(negedge clk);
        scan_now = 1'b0;
    endtask

    task automatic wait_scan(input string tag);
        int n = 0;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        if (!busy) chk({tag, "_busy_rise"}, 32'(busy), 1);
        n = 0;
        while (busy && n < 3000) begin @(negedge clk); n++; end
        if (busy) chk({tag, "_busy_fall"}, 32'(busy), 0);
    endtask

    task automatic read_bank(input string tag, input int ch, input int exp);
        @(negedge clk);
        rd_ch = CH_W'(ch);
        @(negedge clk);
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, s0, n;
        logic seen;

        reset = 1'b0; enable = 1'b0; scan_now = 1'b0; ch_mask = '0;
        err_clr = 1'b0; rd_ch = '0; spur_done = 1'b0; hang_ch = -1;
        mdl_data = '0; mdl_val[0] = 8'h00; mdl_val[1] = 8'h80;
        repeat (3) @(negedge clk);
        chk("rst_conv_start", 32'(conv_start), 0);
        chk("rst_conv_addr", 32'(conv_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_smp_valid", 32'(smp_valid), 0);
        chk("rst_smp_data", 32'(smp_data), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

`ifndef ADC_AVG_EN
        // Single scan across both channels
        ch_mask = 2'b11;
        exp_addr.push_back(0); exp_addr.push_back(1);
        exp_smp.push_back('h000); exp_smp.push_back('h180);
        n0 = n_smp;
        pulse_scan();
        wait_scan("scan1");
        chk("scan1_stores_before_idle", 32'(n_smp - n0), 2);
        chk("scan1_queues_empty", 32'(exp_addr.size() + exp_smp.size()), 0);
        read_bank("scan1_rd_ch1", 1, 'h80);
        read_bank("scan1_rd_ch0", 0, 'h00);

        // Periodic scans on channel 1 only
        ch_mask = 2'b10; mdl_val[1] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            exp_addr.push_back(1); exp_smp.push_back('h133);
        end
        start_cyc.delete();
        s0 = n_start;
        enable = 1'b1;
        n = 0;
        while (n_start - s0 < 3 && n < 600) begin @(negedge clk); n++; end
        enable = 1'b0;
        chk("periodic_three_starts", 32'(n_start - s0), 3);
        repeat (150) @(negedge clk);
        if (start_cyc.size() >= 3) begin
            chk("periodic_gap1", 32'(start_cyc[1] - start_cyc[0]), 100);
            chk("periodic_gap2", 32'(start_cyc[2] - start_cyc[1]), 100);
        end
        chk("periodic_queues_empty", 32'(exp_addr.size() + exp_smp.size()), 0);

        // Preload ch0, then time out ch0 while ch1 still converts
        ch_mask = 2'b01; mdl_val[0] = 8'h5A; mdl_val[1] = 8'h80;
        exp_addr.push_back(0); exp_smp.push_back('h05A);
        pulse_scan();
        wait_scan("preload");
        hang_ch = 0; ch_mask = 2'b11;
        exp_addr.push_back(0); exp_addr.push_back(1);
        exp_smp.push_back('h180);
        @(negedge clk);
        scan_now = 1'b1;
        @(negedge clk);
        scan_now = 1'b0;
        n = 0;
        while (!conv_start && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (!timeout_err && n < 400) begin @(negedge clk); n++; end
        chk("timeout_latency_ok", 32'((n >= 250) && (n <= 251)), 1);
        wait_scan("timeout");
        chk("timeout_queues_empty", 32'(exp_addr.size() + exp_smp.size()), 0);
        read_bank("timeout_ch0_unchanged", 0, 'h5A);
        read_bank("timeout_ch1_converted", 1, 'h80);
        chk("timeout_err_sticky", 32'(timeout_err), 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("timeout_err_cleared", 32'(timeout_err), 0);
        hang_ch = -1;

        // Request while busy is dropped; spurious done while idle is ignored
        mdl_val[0] = 8'h11; mdl_val[1] = 8'h22;
        exp_addr.push_back(0); exp_addr.push_back(1);
        exp_smp.push_back('h011); exp_smp.push_back('h122);
        s0 = n_start;
        pulse_scan();
        repeat (2) @(negedge clk);
        pulse_scan();
        wait_scan("busy_drop");
        repeat (10) @(negedge clk);
        chk("busy_drop_start_count", 32'(n_start - s0), 2);
        n0 = n_smp;
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (5) @(negedge clk);
        chk("spurious_done_no_smp", 32'(n_smp - n0), 0);
        chk("busy_drop_queues_empty", 32'(exp_addr.size() + exp_smp.size()), 0);

        // Empty mask never starts a scan
        ch_mask = 2'b00;
        s0 = n_start; seen = 1'b0;
        pulse_scan();
        for (int i = 0; i < 10; i++) begin
            seen |= busy;
            @(negedge clk);
        end
        chk("mask0_busy", 32'(seen), 0);
        chk("mask0_starts", 32'(n_start - s0), 0);

        // Asynchronous reset while waiting on channel 1
        hang_ch = 1; ch_mask = 2'b10; rd_ch = 1'b1;
        exp_addr.push_back(1);
        pulse_scan();
        repeat (6) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 1);
        chk("pre_reset_rd_data", 32'(rd_data), 'h22);
        reset = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_conv_addr", 32'(conv_addr), 0);
        chk("async_rst_conv_start", 32'(conv_start), 0);
        chk("async_rst_rd_data", 32'(rd_data), 0);
        chk("async_rst_smp_data", 32'(smp_data), 0);
        @(negedge clk);
        reset = 1'b1; hang_ch = -1;
        read_bank("post_rst_bank1", 1, 0);
        read_bank("post_rst_bank0", 0, 0);
        chk("post_rst_queues_empty", 32'(exp_addr.size() + exp_smp.size()), 0);
`else
        // Averaging: only the 4th conversion of ch0 is stored
        ch_mask = 2'b01;
        avg_q.push_back('h10); avg_q.push_back('h20);
        avg_q.push_back('h30); avg_q.push_back('h41);
        for (int i = 0; i < 4; i++) exp_addr.push_back(0);
        exp_smp.push_back('h028);
        n0 = n_smp;
        for (int i = 0; i < 3; i++) begin
            pulse_scan();
            wait_scan("avg_partial");
        end
        chk("avg_no_smp_before_4th", 32'(n_smp - n0), 0);
        read_bank("avg_bank_untouched", 0, 0);
        pulse_scan();
        wait_scan("avg_4th");
        chk("avg_one_smp", 32'(n_smp - n0), 1);
        chk("avg_queues_empty", 32'(exp_addr.size() + exp_smp.size()), 0);
        read_bank("avg_bank_value", 0, 'h28);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
